data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 1024, byte address of data-memory word 0.
REQ-002 SHALL have parameter DEPTH, default 64, number of 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 4, number of ready-low cycles per access (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port mem_r_en  input  1  read request from the MEM stage.
REQ-007 SHALL have port mem_w_en  input  1  write request from the MEM stage.
REQ-008 SHALL have port alu_res  input  32  byte address of the access.
REQ-009 SHALL have port val_rm  input  32  write data.
REQ-010 SHALL have port ready  output  1  high = no access pending; low = pipeline freeze.
REQ-011 SHALL have port read_data  output  32  registered read result.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 In IDLE with (mem_r_en | mem_w_en) high, SHALL latch the address, data and op at the edge, load the counter with LATENCY-1, and go to BUSY (go to DONE if LATENCY = 1).
REQ-014 In BUSY, SHALL decrement the counter each cycle and go to DONE when the counter is 0.
REQ-015 In DONE, SHALL go to IDLE unconditionally; a request is not re-accepted in DONE.
REQ-016 ready SHALL be combinational: low in IDLE when a request is present, low in BUSY, high in DONE, high in IDLE when no request is present.
REQ-017 A request first seen in cycle 0 SHALL see ready low in cycles 0..LATENCY-1 and ready high in cycle LATENCY.
REQ-018 The word index SHALL be (alu_res - BASE_ADDR) >> 2; bits [1:0] are ignored.
REQ-019 A write SHALL commit the latched data to the latched index at the edge ending the DONE cycle.
REQ-020 A read SHALL update read_data at the edge entering DONE; read_data SHALL be valid in DONE and held until the next read completes.
REQ-021 With mem_r_en and mem_w_en both high, SHALL perform the write only and leave read_data unchanged.
REQ-022 Request inputs SHALL be ignored in BUSY and DONE; only the latched values are used.
REQ-023 Memory contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-024 When rst is high at an edge, SHALL enter IDLE, clear the counter, and set read_data to 0 (and addr_err to 0 when present).
REQ-025 rst during BUSY or DONE SHALL abort the access; an aborted write SHALL NOT commit.
REQ-026 rst SHALL take priority over a simultaneous request.

Configuration
REQ-027 With macro DMEM_RANGE_CHECK_EN defined, SHALL add output addr_err (1 bit), high in DONE when the latched address is below BASE_ADDR or the index is >= DEPTH; writes SHALL be suppressed and read_data SHALL load 0 for such accesses.
REQ-028 Without DMEM_RANGE_CHECK_EN, SHALL have no addr_err port, and the index SHALL wrap modulo DEPTH.

Verification
REQ-029 Bench SHALL write val_rm=0xDEADBEEF to alu_res=1024 -> ready low for 4 cycles, high for 1 cycle; a later read of 1024 returns 0xDEADBEEF in its DONE cycle.
REQ-030 Bench SHALL write 0x11 to 1028, then read 1029 -> read_data=0x11, because byte offset bits are ignored.
REQ-031 Bench SHALL change alu_res and val_rm while ready is low during a write to 1032 -> only the originally latched address and data commit.
REQ-032 Bench SHALL assert rst in the 2nd BUSY cycle of a write of 0x55 to 1036 -> next cycle is IDLE with read_data=0; a read of 1036 does not return 0x55.
REQ-033 Bench SHALL issue back-to-back reads of 1024 and 1028 -> each has 4 ready-low cycles, with exactly one ready-high DONE cycle between them.
REQ-034 With DMEM_RANGE_CHECK_EN defined, bench SHALL write 0x77 to 1020 and to 1024+4*64 -> addr_err=1 in DONE and no memory word changes.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory model answering MEM-stage
// load/store requests. An accepted request holds ready low for LATENCY
// cycles (freezing the pipeline), then spends one DONE cycle with ready high.
//
// Parameters:
//   BASE_ADDR - byte address of memory word 0
//   DEPTH     - number of 32-bit words
//   LATENCY   - ready-low cycles per access (1..15)
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   mem_r_en  - read request
//   mem_w_en  - write request (wins over a simultaneous read)
//   alu_res   - byte address of the access (bits [1:0] ignored)
//   val_rm    - write data
//   ready     - combinational: high = no access pending, low = freeze
//   read_data - registered read result, valid in DONE and held afterwards
//   addr_err  - only with DMEM_RANGE_CHECK_EN: high in DONE for an
//               out-of-range access
//
// Optional feature macro: DMEM_RANGE_CHECK_EN (address range checking).
// Without it the word index wraps modulo DEPTH.
module data_mem_responder #(
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] val_rm,
  output logic        ready,
  output logic [31:0] read_data
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int IDX_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [31:0]      wdata_r;
  logic             is_rd_r;
  logic             is_wr_r;
  logic             err_r;

  logic             req_s;
  logic [31:0]      word_s;
  logic [IDX_W-1:0] idx_s;
  logic             err_s;
  logic             op_rd_s;
  logic [IDX_W-1:0] op_idx_s;
  logic             op_err_s;
  logic             enter_done_s;

  // Contents are deliberately never reset.
  logic [31:0]      mem_array_r [DEPTH];

  assign req_s  = mem_r_en | mem_w_en;
  assign word_s = (alu_res - 32'(BASE_ADDR)) >> 2;

`ifdef DMEM_RANGE_CHECK_EN
  assign err_s = (alu_res < 32'(BASE_ADDR)) || (word_s >= 32'(DEPTH));
  assign idx_s = word_s[IDX_W-1:0];
`else
  assign err_s = 1'b0;
  assign idx_s = IDX_W'(word_s % 32'(DEPTH));
`endif

  // With LATENCY = 1 DONE is entered straight from IDLE, before the request
  // has been latched, so the read path must see the live request there.
  always_comb begin
    op_rd_s  = is_rd_r;
    op_idx_s = idx_r;
    op_err_s = err_r;
    if (state_r == IDLE) begin
      op_rd_s  = mem_r_en & ~mem_w_en;
      op_idx_s = idx_s;
      op_err_s = err_s;
    end else begin
      op_rd_s  = is_rd_r;
      op_idx_s = idx_r;
      op_err_s = err_r;
    end
  end

  assign enter_done_s = (state_s == DONE) && (state_r != DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and ready decode.
  always_comb begin
    state_s = state_r;
    ready   = 1'b1;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          ready   = 1'b0;
          state_s = (LATENCY <= 32'd1) ? DONE : BUSY;
        end else begin
          ready   = 1'b1;
          state_s = IDLE;
        end
      end
      BUSY: begin
        ready = 1'b0;
        // cnt_r holds the BUSY cycles still to go including this one.
        if (cnt_r <= 4'd1) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_s = IDLE;
      end
      default: begin
        ready   = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Latency counter and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      wdata_r <= 32'd0;
      is_rd_r <= 1'b0;
      is_wr_r <= 1'b0;
      err_r   <= 1'b0;
    end else if ((state_r == IDLE) && req_s) begin
      cnt_r   <= 4'(LATENCY - 32'd1);
      idx_r   <= idx_s;
      wdata_r <= val_rm;
      is_rd_r <= mem_r_en & ~mem_w_en;
      is_wr_r <= mem_w_en;
      err_r   <= err_s;
    end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Read result, loaded on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (enter_done_s && op_rd_s) begin
      read_data <= op_err_s ? 32'd0 : mem_array_r[op_idx_s];
    end
  end

  // Write commit on the edge leaving DONE; a reset there aborts it.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == DONE) && is_wr_r && !err_r) begin
      mem_array_r[idx_r] <= wdata_r;
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  // Error flag, high only during the DONE cycle of a bad access.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (enter_done_s) begin
      addr_err <= op_err_s;
    end else begin
      addr_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder with a transaction-level model
// checked against the DUT every cycle, plus literal expectations.
module tb_data_mem_responder;

  localparam int          L    = 4;
  localparam int unsigned BASE = 1024;
  localparam int unsigned DEP  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] alu_res = 32'd0;
  logic [31:0] val_rm = 32'd0;
  logic        ready;
  logic [31:0] read_data;
`ifdef DMEM_RANGE_CHECK_EN
  logic        addr_err;
`endif

  int total = 0;
  int passed = 0;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEP), .LATENCY(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .alu_res  (alu_res),
    .val_rm   (val_rm),
    .ready    (ready),
    .read_data(read_data)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .addr_err (addr_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic chk_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    total++;
    if (act === bad) begin
      $display("FAIL %s: got %h, must differ from %h", name, act, bad);
    end else begin
      passed++;
    end
  endtask

  // Model word index and range error, straight from the address rules.
  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    return int'(w % DEP);
  endfunction

  function automatic bit m_err(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    logic [31:0] w;
    w = (a - BASE) >> 2;
    return (a < BASE) || (w >= DEP);
`else
    return (a == 32'd0) && (a != 32'd0);
`endif
  endfunction

  // Model: an accepted access occupies cycles age 0..L-1 (ready low),
  // age L is the DONE cycle.
  logic [31:0] mm [int];
  logic [31:0] exp_rd = 32'd0;
  bit          rd_known = 1'b0;
  logic        exp_err = 1'b0;

  initial begin : compare
    int          age;
    bit          on;
    logic        lr, lw, lerr, exp_ready;
    logic [31:0] ld;
    int          li;
    age = -1; on = 1'b0; lr = 1'b0; lw = 1'b0; lerr = 1'b0; ld = 32'd0; li = 0;
    forever begin
      @(negedge clk);
      if (on) begin
        if (age < 0) exp_ready = !(mem_r_en | mem_w_en);
        else         exp_ready = (age == L);
        chk("model ready", {31'd0, ready}, {31'd0, exp_ready});
        if (rd_known) chk("model read_data", read_data, exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
        chk("model addr_err", {31'd0, addr_err}, {31'd0, exp_err});
`endif
      end
      if (rst) begin
        age = -1; exp_rd = 32'd0; rd_known = 1'b1; exp_err = 1'b0; on = 1'b1;
      end else if (age == L) begin
        if (lw && !lerr) mm[li] = ld;
        age = -1;
        exp_err = 1'b0;
      end else begin
        if (age < 0 && (mem_r_en | mem_w_en)) begin
          lr = mem_r_en; lw = mem_w_en; ld = val_rm;
          li = m_idx(alu_res); lerr = m_err(alu_res);
          age = 0;
        end
        if (age >= 0) begin
          age++;
          if (age == L) begin
            exp_err = lerr;
            if (lr && !lw) begin
              if (lerr) begin
                exp_rd = 32'd0; rd_known = 1'b1;
              end else if (mm.exists(li)) begin
                exp_rd = mm[li]; rd_known = 1'b1;
              end else begin
                rd_known = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // One access, started just after a rising edge; returns the ready-low
  // count and read_data/addr_err seen in the DONE cycle.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble, input bit release_req,
                        output int lows, output logic [31:0] rd, output logic e);
    bit found;
    mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
    lows = 0; rd = 32'd0; e = 1'b0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (ready) begin
        found = 1'b1;
        rd = read_data;
`ifdef DMEM_RANGE_CHECK_EN
        e = addr_err;
`endif
      end else begin
        lows++;
        @(posedge clk); #1;
        if (scramble) begin
          alu_res = 32'd1028;
          val_rm  = 32'h1234_5678;
        end
      end
    end
    if (!found) begin
      total++;
      $display("FAIL access timeout: ready stayed low, expected high within 40 cycles");
    end
    @(posedge clk); #1;
    if (release_req) begin
      mem_r_en = 1'b0; mem_w_en = 1'b0;
    end
  endtask

  initial begin : stim
    int          lows;
    logic [31:0] rd;
    logic        e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset read_data", read_data, 32'd0);
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, 1'b1, lows, rd, e);
    chk("write 1024 low cycles", lows, 32'd4);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("read 1024 low cycles", lows, 32'd4);
    chk("read 1024 data", rd, 32'hDEAD_BEEF);

    access(1'b0, 1'b1, 32'd1028, 32'h0000_0011, 1'b0, 1'b1, lows, rd, e);
    access(1'b1, 1'b0, 32'd1029, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("read 1029 byte offset ignored", rd, 32'h0000_0011);

    access(1'b0, 1'b1, 32'd1032, 32'hCAFE_F00D, 1'b1, 1'b1, lows, rd, e);
    access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("latched write 1032", rd, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("1028 untouched by scramble", rd, 32'h0000_0011);

    access(1'b1, 1'b1, 32'd1040, 32'hA5A5_A5A5, 1'b0, 1'b1, lows, rd, e);
    chk("both-high keeps read_data", rd, 32'h0000_0011);
    access(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("both-high wrote 1040", rd, 32'hA5A5_A5A5);

    // Reset in the 2nd BUSY cycle of a write to 1036.
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 1'b1, lows, rd, e);
    mem_w_en = 1'b1; alu_res = 32'd1036; val_rm = 32'h0000_0055;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_w_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready", {31'd0, ready}, 32'd1);
    chk("abort read_data", read_data, 32'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk_ne("aborted write 1036", rd, 32'h0000_0055);

    // Back-to-back reads: request held through DONE, then readdressed.
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 1'b0, lows, rd, e);
    chk("b2b first low cycles", lows, 32'd4);
    chk("b2b first data", rd, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("b2b second low cycles", lows, 32'd4);
    chk("b2b second data", rd, 32'h0000_0011);

`ifdef DMEM_RANGE_CHECK_EN
    access(1'b0, 1'b1, 32'd1020, 32'h0000_0077, 1'b0, 1'b1, lows, rd, e);
    chk("range err 1020", {31'd0, e}, 32'd1);
    access(1'b0, 1'b1, 32'd1280, 32'h0000_0077, 1'b0, 1'b1, lows, rd, e);
    chk("range err 1280", {31'd0, e}, 32'd1);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("range 1024 intact", rd, 32'hDEAD_BEEF);
    chk("range ok no err", {31'd0, e}, 32'd0);
    access(1'b1, 1'b0, 32'd1280, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("range read loads 0", rd, 32'd0);
    access(1'b1, 1'b0, 32'd1276, 32'd0, 1'b0, 1'b1, lows, rd, e);
    chk("range last word no err", {31'd0, e}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
